// File: rtl/sram2rw_port_ctrl.sv
// Initiator-side controller for a 2RW SRAM macro (two independent ports).
// Each port turns a valid/ready request stream into the macro's active-low
// controls, and collects read data into a small response FIFO. A request is
// only accepted while a FIFO slot is guaranteed for it, so the FIFO cannot
// overflow. A read to an address at or above DEPTH does not touch the macro.
// Instead it returns rdata=0 with err=1, at the same latency and in order.
module sram2rw_port_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 33,
  parameter int DEPTH     = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              rsp2_valid,
  input  logic              rsp2_ready,
  output logic [DATA_W-1:0] rsp2_rdata,
  output logic              rsp2_err,
  output logic              sram_csb1,
  output logic              sram_web1,
  output logic              sram_oeb1,
  output logic [ADDR_W-1:0] sram_a1,
  output logic [DATA_W-1:0] sram_i1,
  input  logic [DATA_W-1:0] sram_o1,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic              sram_oeb2,
  output logic [ADDR_W-1:0] sram_a2,
  output logic [DATA_W-1:0] sram_i2,
  input  logic [DATA_W-1:0] sram_o2
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [CNT_W:0]   CREDITS   = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  // Both ports are bundled so the per-port logic can be generated once.
  logic [1:0]              req_valid;
  logic [1:0]              req_we;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_ready_v;
  logic [1:0][ADDR_W-1:0]  req_addr;
  logic [1:0][DATA_W-1:0]  req_wdata;
  logic [1:0][DATA_W-1:0]  sram_o_v;
  logic                    ww_conflict;

  wire  [1:0]              credit_ok;
  wire  [1:0]              rsp_valid_v;
  wire  [1:0]              rsp_err_v;
  wire  [1:0]              csb_v;
  wire  [1:0]              web_v;
  wire  [1:0]              oeb_v;
  wire  [1:0][ADDR_W-1:0]  a_v;
  wire  [1:0][DATA_W-1:0]  i_v;
  wire  [1:0][DATA_W-1:0]  rdata_v;

  assign req_valid   = {req2_valid, req1_valid};
  assign req_we      = {req2_we, req1_we};
  assign req_addr    = {req2_addr, req1_addr};
  assign req_wdata   = {req2_wdata, req1_wdata};
  assign rsp_ready_v = {rsp2_ready, rsp1_ready};
  assign sram_o_v    = {sram_o2, sram_o1};

  // Two writes to the same in-range word in one cycle: port 1 wins and
  // port 2 is held off for a cycle. This is the only combinational path
  // from request contents to ready.
  assign ww_conflict = req_valid[0] & req_valid[1] & req_we[0] & req_we[1] &
                       (req_addr[0] == req_addr[1]) &
                       ({1'b0, req_addr[0]} < DEPTH_LIM);

  assign req_ready = {credit_ok[1] & ~ww_conflict, credit_ok[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic                    fire;
      logic                    in_range;
      logic                    inflight_reg;
      logic                    inflight_oor_reg;
      logic [CNT_W-1:0]        count_reg;
      logic [PTR_W-1:0]        wr_ptr_reg;
      logic [PTR_W-1:0]        rd_ptr_reg;
      logic [DATA_W-1:0]       fifo_data_reg [RSP_DEPTH];
      logic                    fifo_err_reg  [RSP_DEPTH];
      logic                    push;
      logic                    pop;
      logic                    head_valid;
      logic [CNT_W:0]          credits_used;
      logic                    csb_c;
      logic                    web_c;
      logic                    oeb_c;
      logic [ADDR_W-1:0]       a_c;
      logic [DATA_W-1:0]       i_c;

      assign in_range     = {1'b0, req_addr[gi]} < DEPTH_LIM;
      assign fire         = req_valid[gi] & req_ready[gi];
      // A slot is reserved from fire onwards, so the read in flight counts.
      assign credits_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
      assign credit_ok[gi] = ~reset & (credits_used < CREDITS);
      assign head_valid   = (count_reg != '0);
      assign push         = inflight_reg;
      assign pop          = head_valid & rsp_ready_v[gi];

      // Macro port drive: idle unless an in-range request fires this cycle.
      always_comb begin
        csb_c = 1'b1;
        web_c = 1'b1;
        oeb_c = 1'b1;
        a_c   = '0;
        i_c   = '0;
        if (fire && in_range) begin
          csb_c = 1'b0;
          a_c   = req_addr[gi];
          if (req_we[gi]) begin
            web_c = 1'b0;
            i_c   = req_wdata[gi];
          end else begin
            oeb_c = 1'b0;
          end
        end
      end

      assign csb_v[gi] = csb_c;
      assign web_v[gi] = web_c;
      assign oeb_v[gi] = oeb_c;
      assign a_v[gi]   = a_c;
      assign i_v[gi]   = i_c;

      // Read tracking and FIFO bookkeeping; reset drops any read in flight.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          inflight_reg     <= 1'b0;
          inflight_oor_reg <= 1'b0;
          count_reg        <= '0;
          wr_ptr_reg       <= '0;
          rd_ptr_reg       <= '0;
        end else begin
          inflight_reg     <= fire & ~req_we[gi];
          inflight_oor_reg <= fire & ~req_we[gi] & ~in_range;
          if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
          end
          case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      // FIFO storage: macro data arrives the cycle after the read fired.
      always_ff @(posedge clock) begin
        if (push) begin
          fifo_data_reg[wr_ptr_reg] <= inflight_oor_reg ? '0 : sram_o_v[gi];
          fifo_err_reg[wr_ptr_reg]  <= inflight_oor_reg;
        end
      end

      assign rsp_valid_v[gi] = head_valid;
      assign rdata_v[gi]     = head_valid ? fifo_data_reg[rd_ptr_reg] : '0;
      assign rsp_err_v[gi]   = head_valid & fifo_err_reg[rd_ptr_reg];

      a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count_reg == FULL_CNT)));
    end
  endgenerate

  assign req1_ready = req_ready[0];
  assign req2_ready = req_ready[1];
  assign rsp1_valid = rsp_valid_v[0];
  assign rsp2_valid = rsp_valid_v[1];
  assign rsp1_rdata = rdata_v[0];
  assign rsp2_rdata = rdata_v[1];
  assign rsp1_err   = rsp_err_v[0];
  assign rsp2_err   = rsp_err_v[1];
  assign sram_csb1  = csb_v[0];
  assign sram_csb2  = csb_v[1];
  assign sram_web1  = web_v[0];
  assign sram_web2  = web_v[1];
  assign sram_oeb1  = oeb_v[0];
  assign sram_oeb2  = oeb_v[1];
  assign sram_a1    = a_v[0];
  assign sram_a2    = a_v[1];
  assign sram_i1    = i_v[0];
  assign sram_i2    = i_v[1];

endmodule

// File: tb/tb_sram2rw_port_ctrl.sv
// Testbench for sram2rw_port_ctrl.
// A behavioural macro sits on the SRAM pins. A transaction-level reference
// model predicts the outputs: a shadow memory, plus a per-port queue of
// outstanding reads stamped with the cycle their response becomes due.
// The run is directed scenarios followed by randomized traffic.
module tb_sram2rw_port_ctrl;
  localparam int AW  = 5;
  localparam int DW  = 33;
  localparam int DEP = 24;
  localparam int RD  = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          v, we, rr;
  logic [1:0][AW-1:0]  ad;
  logic [1:0][DW-1:0]  wd;
  logic [1:0][DW-1:0]  so;
  wire  [1:0]          rdy, rv, re, csb, web, oeb;
  wire  [1:0][AW-1:0]  sa;
  wire  [1:0][DW-1:0]  rdat, si;

  always #5 clock = ~clock;

  sram2rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RSP_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .req1_valid(v[0]), .req1_ready(rdy[0]), .req1_we(we[0]), .req1_addr(ad[0]), .req1_wdata(wd[0]),
    .req2_valid(v[1]), .req2_ready(rdy[1]), .req2_we(we[1]), .req2_addr(ad[1]), .req2_wdata(wd[1]),
    .rsp1_valid(rv[0]), .rsp1_ready(rr[0]), .rsp1_rdata(rdat[0]), .rsp1_err(re[0]),
    .rsp2_valid(rv[1]), .rsp2_ready(rr[1]), .rsp2_rdata(rdat[1]), .rsp2_err(re[1]),
    .sram_csb1(csb[0]), .sram_web1(web[0]), .sram_oeb1(oeb[0]), .sram_a1(sa[0]), .sram_i1(si[0]), .sram_o1(so[0]),
    .sram_csb2(csb[1]), .sram_web2(web[1]), .sram_oeb2(oeb[1]), .sram_a2(sa[1]), .sram_i2(si[1]), .sram_o2(so[1])
  );

  // Behavioural 2RW macro: reads return pre-write contents, data valid next cycle.
  logic [DW-1:0] macro_mem [32];
  always @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (!csb[p] && !oeb[p]) so[p] <= macro_mem[sa[p]];
      if (!csb[p] && !web[p]) macro_mem[sa[p]] <= si[p];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } rsp_t;

  rsp_t          mq [2][$];
  logic [DW-1:0] ref_mem [DEP];
  int            cyc;
  int            checks;
  int            errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    v  = '0;
    we = '0;
    ad = '0;
    wd = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    v[p]  = 1'b1;
    we[p] = w;
    ad[p] = a;
    wd[p] = d;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic step();
    bit [1:0] exp_rdy, exp_v, fire;
    bit       conflict, inr;
    rsp_t     e;
    @(negedge clock);
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
    end
    conflict = v[0] && v[1] && we[0] && we[1] && (ad[0] == ad[1]) && (int'(ad[0]) < DEP);
    for (int p = 0; p < 2; p++) begin
      exp_rdy[p] = !reset && (mq[p].size() < RD);
      exp_v[p]   = !reset && (mq[p].size() > 0) && (mq[p][0].due <= cyc);
    end
    if (conflict) exp_rdy[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      check_val($sformatf("p%0d_req_ready", p + 1), 64'(rdy[p]), 64'(exp_rdy[p]));
      check_val($sformatf("p%0d_rsp_valid", p + 1), 64'(rv[p]), 64'(exp_v[p]));
      if (exp_v[p]) begin
        check_val($sformatf("p%0d_rsp_rdata", p + 1), 64'(rdat[p]), 64'(mq[p][0].data));
        check_val($sformatf("p%0d_rsp_err", p + 1), 64'(re[p]), 64'(mq[p][0].err));
      end
      if (reset) begin
        check_val($sformatf("p%0d_rst_rdata", p + 1), 64'(rdat[p]), 64'(0));
        check_val($sformatf("p%0d_rst_err", p + 1), 64'(re[p]), 64'(0));
      end
      fire[p] = v[p] && exp_rdy[p];
      inr     = int'(ad[p]) < DEP;
      check_val($sformatf("p%0d_csb", p + 1), 64'(csb[p]), 64'(!(fire[p] && inr)));
      if (fire[p] && inr) begin
        check_val($sformatf("p%0d_web", p + 1), 64'(web[p]), 64'(!we[p]));
        check_val($sformatf("p%0d_oeb", p + 1), 64'(oeb[p]), 64'(we[p]));
        check_val($sformatf("p%0d_addr", p + 1), 64'(sa[p]), 64'(ad[p]));
        if (we[p]) check_val($sformatf("p%0d_wdata", p + 1), 64'(si[p]), 64'(wd[p]));
      end else if (!fire[p]) begin
        check_val($sformatf("p%0d_idle", p + 1), 64'({web[p], oeb[p], sa[p], si[p]}),
                  64'({2'b11, {AW{1'b0}}, {DW{1'b0}}}));
      end
    end
    // Model update: pops, then reads (old contents), then writes.
    for (int p = 0; p < 2; p++) begin
      if (exp_v[p] && rr[p]) begin
        $display("cyc %0d p%0d RSP data %h err %0d", cyc, p + 1, mq[p][0].data, mq[p][0].err);
        void'(mq[p].pop_front());
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fire[p]) begin
        $display("cyc %0d p%0d %s addr %0d data %h", cyc, p + 1, we[p] ? "WR" : "RD", ad[p], wd[p]);
        if (!we[p]) begin
          e.err  = int'(ad[p]) >= DEP;
          e.data = '0;
          if (!e.err) e.data = ref_mem[ad[p]];
          e.due  = cyc + 2;
          mq[p].push_back(e);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fire[p] && we[p] && (int'(ad[p]) < DEP)) ref_mem[ad[p]] = wd[p];
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  initial begin
    logic [DW-1:0] init_word;
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    rr     = 2'b11;
    idle();
    for (int i = 0; i < 32; i++) begin
      init_word = {1'($urandom_range(0, 1)), 32'($urandom)};
      macro_mem[i] <= init_word;
      if (i < DEP) ref_mem[i] = init_word;
    end
    step();
    step();
    reset = 1'b0;
    step();

    // Write then read across ports.
    set_req(0, 1'b1, 5'd5, 33'h1_2345_6789); step(); idle();
    set_req(1, 1'b0, 5'd5, '0); step(); idle();
    repeat (3) step();

    // Same-address write-write: port 2 held off one cycle.
    set_req(0, 1'b1, 5'd7, 33'h0AAAA);
    set_req(1, 1'b1, 5'd7, 33'h05555); step();
    v[0] = 1'b0; step(); idle();
    set_req(0, 1'b0, 5'd7, '0); step(); idle();
    repeat (3) step();

    // Read and write of the same word on opposite ports.
    set_req(0, 1'b1, 5'd3, 33'h1); step(); idle();
    set_req(0, 1'b1, 5'd3, 33'h7);
    set_req(1, 1'b0, 5'd3, '0); step(); idle();
    repeat (3) step();

    // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls.
    rr[0] = 1'b0;
    set_req(0, 1'b0, 5'd5, '0); step();
    ad[0] = 5'd7; step();
    ad[0] = 5'd3; repeat (3) step();
    idle(); step();
    rr[0] = 1'b1;
    repeat (5) step();

    // Out-of-range read.
    set_req(0, 1'b0, 5'd30, '0); step(); idle();
    repeat (3) step();

    // Reset one cycle after a read fire drops the read.
    set_req(1, 1'b0, 5'd7, '0); step(); idle();
    reset = 1'b1; step(); step();
    reset = 1'b0;
    repeat (4) step();

    // Randomized traffic with occasional conflicts and resets.
    repeat (1500) begin
      for (int p = 0; p < 2; p++) begin
        v[p]  = $urandom_range(0, 9) < 7;
        we[p] = 1'($urandom_range(0, 1));
        ad[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
        wd[p] = {1'($urandom_range(0, 1)), 32'($urandom)};
        rr[p] = $urandom_range(0, 3) != 0;
      end
      if ($urandom_range(0, 3) == 0) ad[1] = ad[0];
      reset = $urandom_range(0, 299) == 0;
      step();
    end
    reset = 1'b0;
    idle();
    rr = 2'b11;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
